jk_count_ctrl: RTL and testbench

Sequencer that drives the J/K inputs of a WIDTH-bit bank of jk_ff cells so the bank behaves as a loadable, modulo-MOD up/down counter, or as a timed hold.
Each operation is triggered by a start pulse, runs for a programmed number of clock steps, and ends with a one-cycle done pulse.
The block is the control layer above the single-bit JK flip-flop primitive. It is used wherever a counter/timer built from JK cells is needed.

---
 rtl/jk_ctrl_pkg.sv | 41 ++++
 rtl/jk_ff.sv | 36 +++
 rtl/jk_count_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_jk_count_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_ctrl_pkg.sv
// jk_ctrl_pkg
// Shared types for the JK-cell counter controller:
//   state_t   - controller FSM states
//   mode_t    - operation codes carried on the mode input
//   jk_code_t - per-bit {J,K} excitation codes for a jk_ff cell
// The helper functions map a desired bit action onto a {J,K} drive code.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    // Bit order is {J,K}.
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_code_t;

    // Counting uses toggle-only excitation: flip exactly the bits that differ.
    function automatic jk_code_t toggle_code(input logic flip);
        return flip ? JK_TGL : JK_HOLD;
    endfunction

    // Loading forces each bit directly, independent of its present value.
    function automatic jk_code_t load_code(input logic val);
        return val ? JK_SET : JK_CLR;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// jk_ff
// Single-bit JK flip-flop primitive with synchronous active-low clear.
// Ports:
//   clk   - rising-edge clock
//   n_rst - synchronous active-low reset, clears q
//   j, k  - excitation: 00 hold, 01 clear, 10 set, 11 toggle
//   q     - stored bit
//   q_bar - complement of q
module jk_ff (
    input  logic clk,
    input  logic n_rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            q_reg <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q_reg <= q_reg;
                2'b01:   q_reg <= 1'b0;
                2'b10:   q_reg <= 1'b1;
                default: q_reg <= ~q_reg;
            endcase
        end
    end

    assign q     = q_reg;
    assign q_bar = ~q_reg;

endmodule

// File: rtl/jk_count_ctrl.sv
// jk_count_ctrl
// Sequencer driving a WIDTH-bit bank of jk_ff cells as a loadable modulo-MOD
// up/down counter or as a timed hold. Each operation is launched by a start
// pulse in IDLE and ends with a one-cycle done pulse.
// Ports:
//   clk      - rising-edge clock
//   n_rst    - synchronous active-low reset (controller and every jk_ff cell)
//   start    - single-cycle request, sampled only in IDLE
//   mode     - 00 HOLD, 01 UP, 10 DOWN, 11 LOAD (latched with start)
//   load_val - value for LOAD (latched with start)
//   run_len  - number of steps for HOLD/UP/DOWN (latched with start)
//   q        - bank value (jk_ff Q outputs)
//   busy     - high while an operation is in LOAD or RUN
//   done     - one-cycle pulse ending each operation
//   wrap     - one-cycle pulse after a step crossing MOD-1 <-> 0
module jk_count_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [LEN_W-1:0] run_len,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MOD_M1  = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state_reg, state_next;
    mode_t            mode_reg;
    logic [WIDTH-1:0] load_val_reg;
    logic [LEN_W-1:0] run_len_reg;
    logic [LEN_W-1:0] step_cnt_reg;
    logic             wrap_reg;

    logic [WIDTH-1:0] q_bank;
    logic [WIDTH-1:0] q_bar_bank;
    logic [WIDTH-1:0] count_next;
    logic             count_wrap;
    logic             q_out_of_range;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    // ------------------------------------------------------------------
    // Sequential state: FSM register, latched operands, step counter, wrap
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            mode_reg     <= MODE_HOLD;
            load_val_reg <= '0;
            run_len_reg  <= '0;
            step_cnt_reg <= '0;
            wrap_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Registered so the pulse lines up with the q change it describes.
            wrap_reg  <= (state_reg == RUN) && count_wrap;
            if (state_reg == IDLE && start) begin
                mode_reg     <= mode_t'(mode);
                load_val_reg <= load_val;
                run_len_reg  <= run_len;
                step_cnt_reg <= '0;
            end else if (state_reg == RUN) begin
                step_cnt_reg <= step_cnt_reg + LEN_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (mode_t'(mode) == MODE_LOAD) begin
                        state_next = LOAD;
                    end else if (run_len != '0) begin
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            LOAD: state_next = DONE;
            RUN: begin
                // The step taken on this edge is the run_len-th one.
                if (step_cnt_reg == run_len_reg - LEN_ONE) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Count target. Compared one bit wider so MOD == 2**WIDTH never
    // reports an out-of-range value.
    // ------------------------------------------------------------------
    assign q_out_of_range = ({1'b0, q_bank} >= MOD_EXT);

    always_comb begin
        count_next = q_bank;
        count_wrap = 1'b0;
        case (mode_reg)
            MODE_UP: begin
                if (q_bank >= MOD_M1) begin
                    count_next = '0;
                    count_wrap = 1'b1;
                end else begin
                    count_next = q_bank + Q_ONE;
                end
            end
            MODE_DOWN: begin
                if (q_bank == '0 || q_out_of_range) begin
                    count_next = MOD_M1;
                    count_wrap = 1'b1;
                end else begin
                    count_next = q_bank - Q_ONE;
                end
            end
            default: begin
                count_next = q_bank;
                count_wrap = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-bit excitation and the jk_ff bank
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_code_t bit_code;

        always_comb begin
            bit_code = JK_HOLD;
            if (state_reg == LOAD) begin
                bit_code = load_code(load_val_reg[gi]);
            end else if (state_reg == RUN) begin
                bit_code = toggle_code(q_bank[gi] ^ count_next[gi]);
            end
        end

        assign j_vec[gi] = bit_code[1];
        assign k_vec[gi] = bit_code[0];

        jk_ff u_jk_ff (
            .clk   (clk),
            .n_rst (n_rst),
            .j     (j_vec[gi]),
            .k     (k_vec[gi]),
            .q     (q_bank[gi]),
            .q_bar (q_bar_bank[gi])
        );
    end

    // The complement outputs carry no extra information; they only serve as
    // a consistency check on the cell bank.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            assert (q_bar_bank == ~q_bank);
        end
    end

    assign q    = q_bank;
    assign busy = (state_reg == LOAD) || (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// tb_jk_count_ctrl
// Directed scoreboard bench for jk_count_ctrl (WIDTH=4, MOD=10, LEN_W=8).
// Stimulus pushes the hand-computed per-cycle response of each operation;
// a forked monitor pops one record for every cycle in which the DUT shows
// activity (busy, done or wrap) and compares it.
module tb_jk_count_ctrl;
    import jk_ctrl_pkg::*;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] load_val = '0;
    logic [LEN_W-1:0] run_len = '0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        logic             wrap;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;

    jk_count_ctrl #(.WIDTH(WIDTH), .MOD(MOD), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .mode     (mode),
        .load_val (load_val),
        .run_len  (run_len),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic expect_rec(input logic [WIDTH-1:0] eq, input logic eb,
                              input logic ed, input logic ew);
        rec_t r;
        r.q = eq; r.busy = eb; r.done = ed; r.wrap = ew;
        exp_q.push_back(r);
    endtask

    task automatic start_op(input logic [1:0] m, input logic [WIDTH-1:0] lv,
                            input logic [LEN_W-1:0] rl);
        @(negedge clk);
        mode = m; load_val = lv; run_len = rl; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: no done pulse within 60 cycles, required one", name);
        end
    endtask

    task automatic check_idle(input string name, input logic [WIDTH-1:0] eq);
        n_vec++;
        if (q !== eq || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got q=%0d busy=%b done=%b wrap=%b, required q=%0d busy=0 done=0 wrap=0",
                     name, q, busy, done, wrap, eq);
        end
    endtask

    initial begin
        // Power-on reset
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_state", 4'd0);
        n_rst = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (busy || done || wrap) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_activity: got q=%0d busy=%b done=%b wrap=%b, required no activity",
                                 q, busy, done, wrap);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (q !== mon_e.q || busy !== mon_e.busy ||
                            done !== mon_e.done || wrap !== mon_e.wrap) begin
                            n_fail++;
                            $display("FAIL scoreboard: got q=%0d busy=%b done=%b wrap=%b, required q=%0d busy=%b done=%b wrap=%b",
                                     q, busy, done, wrap, mon_e.q, mon_e.busy, mon_e.done, mon_e.wrap);
                        end
                    end
                end
                if (dut.state_reg == RUN) begin
                    n_vec++;
                    if (dut.j_vec !== dut.k_vec) begin
                        n_fail++;
                        $display("FAIL run_excitation: got j=%b k=%b, required j==k", dut.j_vec, dut.k_vec);
                    end
                end
            end
        join_none

        // 1. Reset mid-run: UP run_len=20 aborted at step 5
        for (int k = 0; k <= 5; k++) expect_rec(4'(k), 1'b1, 1'b0, 1'b0);
        start_op(MODE_UP, 4'd0, 8'd20);
        repeat (5) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check_idle("reset_mid_run_1", 4'd0);
        @(negedge clk);
        check_idle("reset_mid_run_2", 4'd0);
        n_rst = 1'b1;

        // 2. LOAD 7, then UP run_len=5 -> 8,9,0,1,2 with wrap on 9->0
        expect_rec(4'd0, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd7, 1'b0, 1'b1, 1'b0);
        start_op(MODE_LOAD, 4'd7, 8'd0);
        wait_done("load_7");
        expect_rec(4'd7, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd8, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd9, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd0, 1'b1, 1'b0, 1'b1);
        expect_rec(4'd1, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd2, 1'b0, 1'b1, 1'b0);
        start_op(MODE_UP, 4'd0, 8'd5);
        wait_done("up_5");
        @(negedge clk);
        check_idle("up_5_after", 4'd2);

        // 3. LOAD 1, then DOWN run_len=3 -> 0,9,8 with wrap on 0->9
        expect_rec(4'd2, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd1, 1'b0, 1'b1, 1'b0);
        start_op(MODE_LOAD, 4'd1, 8'd0);
        wait_done("load_1");
        expect_rec(4'd1, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd0, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd9, 1'b1, 1'b0, 1'b1);
        expect_rec(4'd8, 1'b0, 1'b1, 1'b0);
        start_op(MODE_DOWN, 4'd0, 8'd3);
        wait_done("down_3");

        // 4. LOAD 3, then HOLD run_len=4 -> q stays 3
        expect_rec(4'd8, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd3, 1'b0, 1'b1, 1'b0);
        start_op(MODE_LOAD, 4'd3, 8'd0);
        wait_done("load_3");
        for (int k = 0; k < 4; k++) expect_rec(4'd3, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd3, 1'b0, 1'b1, 1'b0);
        start_op(MODE_HOLD, 4'd0, 8'd4);
        wait_done("hold_4");
        @(negedge clk);
        check_idle("hold_4_after", 4'd3);

        // 5. UP run_len=0 -> immediate done; then run_len=6 with a stray start
        expect_rec(4'd3, 1'b0, 1'b1, 1'b0);
        start_op(MODE_UP, 4'd0, 8'd0);
        wait_done("up_0");
        expect_rec(4'd3, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd4, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd5, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd6, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd7, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd8, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd9, 1'b0, 1'b1, 1'b0);
        start_op(MODE_UP, 4'd0, 8'd6);
        @(negedge clk);
        mode = MODE_LOAD; load_val = 4'd0; run_len = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("up_6");
        repeat (4) @(negedge clk);
        check_idle("up_6_single_done", 4'd9);

        // 6. Out-of-range q corrected on the first step
        expect_rec(4'd9, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd12, 1'b0, 1'b1, 1'b0);
        start_op(MODE_LOAD, 4'd12, 8'd0);
        wait_done("load_12_a");
        expect_rec(4'd12, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd0, 1'b0, 1'b1, 1'b1);
        start_op(MODE_UP, 4'd0, 8'd1);
        wait_done("up_from_12");
        expect_rec(4'd0, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd12, 1'b0, 1'b1, 1'b0);
        start_op(MODE_LOAD, 4'd12, 8'd0);
        wait_done("load_12_b");
        expect_rec(4'd12, 1'b1, 1'b0, 1'b0);
        expect_rec(4'd9, 1'b0, 1'b1, 1'b1);
        start_op(MODE_DOWN, 4'd0, 8'd1);
        wait_done("down_from_12");
        repeat (3) @(negedge clk);
        check_idle("final_idle", 4'd9);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending records, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
